fpaddsub: RTL and testbench
===========================

FPADDSUB -- requirements
Module: fpaddsub

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width; legal range 4..11.
REQ-002 Parameter MAN_W, default 23, stored fraction width; legal range 4..52; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  1  0 = a+b, 1 = a-b.
REQ-007 a, b  input  W each  IEEE-754-style operands.
REQ-008 sum  output  W  result, registered, held until the next result.
REQ-009 done  output  1  one-cycle result strobe.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact}, valid with done, held with sum.

Function
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND, OUT.
REQ-013 IDLE with start=1 SHALL register a, b and op, and SHALL unpack the operands; sub SHALL invert b's sign.
REQ-014 start while busy SHALL be ignored, with no queueing.
REQ-015 Normal path: IDLE->ALIGN->ADD->NORM->ROUND->OUT->IDLE, one state per clock; done SHALL rise in the cycle after the 5th rising edge following the edge that samples start.
REQ-016 Special path: when either operand is NaN/Inf, or both are zero, IDLE SHALL go directly to OUT; done SHALL rise one cycle after the start edge.
REQ-017 ALIGN SHALL right-shift the smaller-exponent significand by the exponent difference, keeping guard, round and sticky bits.
REQ-018 A shift of MAN_W+3 or more SHALL collapse the shifted significand into sticky.
REQ-019 ADD SHALL add or subtract the magnitudes by effective sign into a MAN_W+5-bit datapath; a negative difference SHALL be negated and the result sign set accordingly.
REQ-020 NORM SHALL correct carry-out with a 1-bit right shift and exp+1; leading zeros SHALL be removed in one cycle via the leading-zero count.
REQ-021 ROUND SHALL round to nearest, ties to even; rounding carry SHALL renormalise and increment the exponent.
REQ-022 inexact SHALL be set iff any of guard, round or sticky is nonzero.
REQ-023 Subnormal inputs SHALL be treated as signed zero; a result exponent <= 0 SHALL flush to signed zero and set underflow.
REQ-024 A result exponent >= all-ones SHALL produce signed Inf and set overflow and inexact.
REQ-025 Any NaN input, or Inf minus Inf, SHALL return canonical qNaN (sign 0, exponent all-ones, fraction MSB 1) and set invalid.
REQ-026 Inf plus finite SHALL return that Inf with no flags.
REQ-027 An exact cancellation SHALL return +0, except that -0 + -0 SHALL return -0.
REQ-028 OUT SHALL register sum and flags and pulse done; the next start SHALL be accepted no earlier than the cycle after done.

Reset
REQ-029 reset low SHALL immediately force state IDLE, sum=0, flags=0, done=0 and busy=0, regardless of clk.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be serviced normally.

Structure
REQ-031 Package fpaddsub_pkg SHALL hold the state enum, flag bit indices, rounding constants and the qNaN/Inf constructor functions parametrised by EXP_W/MAN_W.
REQ-032 A single sub-module fpaddsub_lzc, a parametrised leading-zero counter, SHALL serve NORM.
REQ-033 Every other element SHALL live in fpaddsub; the implementation targets 120-400 lines of RTL.

Verification
REQ-034 Add: a=3F800000, b=40000000, op=0 -> sum=40400000, flags=0000, done 5 cycles after start.
REQ-035 Cancel and tie: 3F800000 - 3F800000 -> 00000000, flags=0000; 3F800000 + 33800000 -> 3F800000 (tie to even), inexact=1.
REQ-036 Overflow: 7F7FFFFF + 7F7FFFFF -> 7F800000, overflow=1, inexact=1.
REQ-037 Invalid: 7F800000 - 7F800000 (op=1) -> 7FC00000, invalid=1, done 1 cycle after start.
REQ-038 Reset mid-op: start 3F800000+40000000, drive reset low during NORM -> done never pulses, sum=0; start again after release -> 40400000.
REQ-039 Half precision: EXP_W=5, MAN_W=10, 3C00 + 4000 -> 4200, 7BFF + 7BFF -> 7C00 with overflow=1.

Source files
------------

// File: rtl/fpaddsub_pkg.sv
// Shared definitions for the fpaddsub floating-point adder/subtractor.
// Holds the FSM state type, flag bit positions, rounding-field layout and
// constructors for the special encodings (canonical qNaN, signed Inf). The
// constructors take the field widths as arguments and return a 64-bit word
// (the widest legal format); callers truncate to their own word width.
package fpaddsub_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StRound,
    StOut
  } state_e;

  // Bit positions inside flags = {invalid, overflow, underflow, inexact}.
  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  // Extra bits carried below the significand LSB and their positions.
  localparam int unsigned GrsW      = 3;
  localparam int unsigned RndGuard  = 2;
  localparam int unsigned RndRound  = 1;
  localparam int unsigned RndSticky = 0;

  // Signed working exponent: wide enough for biased exp + 1 and exp - lzc.
  localparam int unsigned ExpIntW = 16;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_word(input int unsigned exp_w,
                                            input int unsigned man_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << man_w;
    w = w | (64'd1 << (man_w - 1));
    return w;
  endfunction

  // Signed infinity: exponent all ones, fraction zero.
  function automatic logic [63:0] inf_word(input logic        sign,
                                           input int unsigned exp_w,
                                           input int unsigned man_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << man_w;
    w = w | (64'(sign) << (exp_w + man_w));
    return w;
  endfunction

endpackage

// File: rtl/fpaddsub_lzc.sv
// Parametrised leading-zero counter.
//   data_i  : vector to scan, MSB first
//   count_o : number of zeros above the most significant one; Width when
//             data_i is all zeros
module fpaddsub_lzc #(
  parameter int unsigned Width = 27,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  count_o
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    count_o = CntW'(Width);
    for (int unsigned i = 0; i < Width; i++) begin
      if (data_i[i]) begin
        count_o = CntW'(Width - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpaddsub.sv
// Multi-cycle IEEE-754-style floating-point adder/subtractor.
// Normal operands walk IDLE->ALIGN->ADD->NORM->ROUND->OUT; NaN/Inf/both-zero
// operands are resolved while idle and jump straight to OUT. Subnormal inputs
// are read as signed zero, results that would be subnormal flush to zero.
// Rounding is to nearest, ties to even.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   start : request, sampled only while idle
//   op    : 0 = a + b, 1 = a - b
//   a, b  : operands, {sign, exponent[EXP_W], fraction[MAN_W]}
//   sum   : registered result, held until the next result
//   done  : one-cycle strobe when sum/flags update
//   busy  : high whenever the FSM is not idle
//   flags : {invalid, overflow, underflow, inexact}, held with sum
module fpaddsub
  import fpaddsub_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   done,
  output logic                   busy,
  output logic [3:0]             flags
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SigW = MAN_W + 1 + GrsW;  // hidden + fraction + g/r/s
  localparam int unsigned SW   = SigW + 1;          // plus carry-out bit
  localparam int unsigned RndW = MAN_W + 2;         // rounded significand + carry
  localparam int unsigned CntW = $clog2(SigW + 1);

  localparam logic [EXP_W-1:0]          ExpAllOnes = '1;
  localparam logic signed [ExpIntW-1:0] ExpMaxS    = ExpIntW'((1 << EXP_W) - 1);
  localparam logic signed [ExpIntW-1:0] ExpZeroS   = '0;
  localparam logic signed [ExpIntW-1:0] ExpOneS    = ExpIntW'(1);
  localparam logic [W-1:0]              QNan       = W'(qnan_word(EXP_W, MAN_W));

  state_e state_q, state_d;
  logic   out_load;

  // Unpacked operands (captured on start).
  logic               sign_a_q, sign_b_q;
  logic [EXP_W-1:0]   exp_a_q, exp_b_q;
  logic [MAN_W:0]     man_a_q, man_b_q;
  // Aligned significands.
  logic               sign_big_q, sign_small_q;
  logic [SigW-1:0]    sig_big_q, sig_small_q;
  // Working magnitude, sign and exponent through ADD/NORM/ROUND.
  logic [SW-1:0]      mag_q;
  logic               sign_q, zero_q;
  logic signed [ExpIntW-1:0] exp_q;
  // Result staged for OUT.
  logic [W-1:0]       res_q;
  logic [3:0]         res_flags_q;
  // Architectural outputs.
  logic [W-1:0]       sum_q;
  logic [3:0]         flags_q;
  logic               done_q;

  // ---------------------------------------------------------------------------
  // Input unpack and special-case resolution (used only in IDLE)
  // ---------------------------------------------------------------------------
  logic             in_sa, in_sb;
  logic [EXP_W-1:0] in_ea, in_eb;
  logic [MAN_W-1:0] in_fa, in_fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             special;
  logic [W-1:0]     spec_res;
  logic [3:0]       spec_flags;

  assign in_sa  = a[W-1];
  assign in_sb  = b[W-1] ^ op;  // subtraction flips b's sign
  assign in_ea  = a[W-2:MAN_W];
  assign in_eb  = b[W-2:MAN_W];
  assign in_fa  = a[MAN_W-1:0];
  assign in_fb  = b[MAN_W-1:0];
  // Exponent zero covers true zeros and subnormals alike.
  assign a_zero = (in_ea == '0);
  assign b_zero = (in_eb == '0);
  assign a_inf  = (in_ea == ExpAllOnes) && (in_fa == '0);
  assign b_inf  = (in_eb == ExpAllOnes) && (in_fb == '0);
  assign a_nan  = (in_ea == ExpAllOnes) && (in_fa != '0);
  assign b_nan  = (in_eb == ExpAllOnes) && (in_fb != '0);

  always_comb begin
    special    = 1'b0;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (in_sa != in_sb))) begin
      special                 = 1'b1;
      spec_res                = QNan;
      spec_flags[FlagInvalid] = 1'b1;
    end else if (a_inf) begin
      special  = 1'b1;
      spec_res = W'(inf_word(in_sa, EXP_W, MAN_W));
    end else if (b_inf) begin
      special  = 1'b1;
      spec_res = W'(inf_word(in_sb, EXP_W, MAN_W));
    end else if (a_zero && b_zero) begin
      // Only -0 + -0 keeps the negative sign.
      special  = 1'b1;
      spec_res = {in_sa & in_sb, (W - 1)'(0)};
    end
  end

  // ---------------------------------------------------------------------------
  // ALIGN: shift the smaller-exponent significand right, folding lost bits
  // into sticky
  // ---------------------------------------------------------------------------
  logic             a_big;
  logic [EXP_W-1:0] exp_diff;
  logic [SigW-1:0]  small_ext, small_shift, small_lost, align_small, align_big;
  logic signed [ExpIntW-1:0] align_exp;

  always_comb begin
    a_big       = (exp_a_q >= exp_b_q);
    exp_diff    = a_big ? (exp_a_q - exp_b_q) : (exp_b_q - exp_a_q);
    align_big   = {a_big ? man_a_q : man_b_q, GrsW'(0)};
    small_ext   = {a_big ? man_b_q : man_a_q, GrsW'(0)};
    align_exp   = ExpIntW'(a_big ? exp_a_q : exp_b_q);
    small_shift = small_ext >> exp_diff;
    small_lost  = small_ext & ((SigW'(1) << exp_diff) - SigW'(1));
    if (32'(exp_diff) >= MAN_W + 3) begin
      align_small = SigW'(|small_ext);
    end else begin
      align_small            = small_shift;
      align_small[RndSticky] = small_shift[RndSticky] | (|small_lost);
    end
  end

  // ---------------------------------------------------------------------------
  // ADD: magnitude add/subtract by effective sign
  // ---------------------------------------------------------------------------
  logic [SW-1:0] big_x, small_x, add_raw, add_mag;
  logic          add_sign;

  always_comb begin
    big_x   = {1'b0, sig_big_q};
    small_x = {1'b0, sig_small_q};
    add_raw = '0;
    if (sign_big_q == sign_small_q) begin
      add_mag  = big_x + small_x;
      add_sign = sign_big_q;
    end else begin
      add_raw = big_x - small_x;
      // Negative only when exponents were equal and b's significand larger.
      if (add_raw[SW-1]) begin
        add_mag  = small_x - big_x;
        add_sign = sign_small_q;
      end else begin
        add_mag  = add_raw;
        add_sign = sign_big_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // NORM: carry-out right shift, otherwise single-step left shift by lzc
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] lz;
  logic [SW-1:0]   norm_mag;
  logic signed [ExpIntW-1:0] norm_exp;
  logic            norm_zero;

  fpaddsub_lzc #(
    .Width (SigW),
    .CntW  (CntW)
  ) u_lzc (
    .data_i  (mag_q[SW-2:0]),
    .count_o (lz)
  );

  always_comb begin
    norm_zero = (mag_q == '0);
    if (mag_q[SW-1]) begin
      norm_mag            = {1'b0, mag_q[SW-1:1]};
      norm_mag[RndSticky] = mag_q[1] | mag_q[0];
      norm_exp            = exp_q + ExpOneS;
    end else begin
      norm_mag = mag_q << lz;
      norm_exp = exp_q - ExpIntW'(lz);
    end
  end

  // ---------------------------------------------------------------------------
  // ROUND: nearest-even, then range checks
  // ---------------------------------------------------------------------------
  logic            rnd_g, rnd_r, rnd_s, rnd_lsb, rnd_up, rnd_inexact;
  logic [RndW-1:0] rnd_sig;
  logic [MAN_W-1:0] rnd_frac;
  logic signed [ExpIntW-1:0] rnd_exp;
  logic [W-1:0]    rnd_res;
  logic [3:0]      rnd_flags;

  always_comb begin
    rnd_g       = mag_q[RndGuard];
    rnd_r       = mag_q[RndRound];
    rnd_s       = mag_q[RndSticky];
    rnd_lsb     = mag_q[GrsW];
    rnd_inexact = rnd_g | rnd_r | rnd_s;
    rnd_up      = rnd_g & (rnd_r | rnd_s | rnd_lsb);
    rnd_sig     = {1'b0, mag_q[SW-2:GrsW]} + RndW'(rnd_up);
    if (rnd_sig[RndW-1]) begin
      // All-ones significand rounded up: becomes 1.000, exponent + 1.
      rnd_frac = rnd_sig[MAN_W:1];
      rnd_exp  = exp_q + ExpOneS;
    end else begin
      rnd_frac = rnd_sig[MAN_W-1:0];
      rnd_exp  = exp_q;
    end
    rnd_flags = '0;
    if (zero_q) begin
      rnd_res = '0;
    end else if (rnd_exp >= ExpMaxS) begin
      rnd_res                   = W'(inf_word(sign_q, EXP_W, MAN_W));
      rnd_flags[FlagOverflow]   = 1'b1;
      rnd_flags[FlagInexact]    = 1'b1;
    end else if (rnd_exp <= ExpZeroS) begin
      rnd_res                   = {sign_q, (W - 1)'(0)};
      rnd_flags[FlagUnderflow]  = 1'b1;
      rnd_flags[FlagInexact]    = rnd_inexact;
    end else begin
      rnd_res                   = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
      rnd_flags[FlagInexact]    = rnd_inexact;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = special ? StOut : StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StRound;
      StRound: state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = 1'b1;
    out_load = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StOut:   out_load = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      exp_a_q      <= '0;
      exp_b_q      <= '0;
      man_a_q      <= '0;
      man_b_q      <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      sig_big_q    <= '0;
      sig_small_q  <= '0;
      mag_q        <= '0;
      sign_q       <= 1'b0;
      zero_q       <= 1'b0;
      exp_q        <= '0;
      res_q        <= '0;
      res_flags_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sign_a_q    <= in_sa;
            sign_b_q    <= in_sb;
            exp_a_q     <= in_ea;
            exp_b_q     <= in_eb;
            man_a_q     <= a_zero ? '0 : {1'b1, in_fa};
            man_b_q     <= b_zero ? '0 : {1'b1, in_fb};
            res_q       <= spec_res;
            res_flags_q <= spec_flags;
          end
        end
        StAlign: begin
          sign_big_q   <= a_big ? sign_a_q : sign_b_q;
          sign_small_q <= a_big ? sign_b_q : sign_a_q;
          sig_big_q    <= align_big;
          sig_small_q  <= align_small;
          exp_q        <= align_exp;
        end
        StAdd: begin
          mag_q  <= add_mag;
          sign_q <= add_sign;
        end
        StNorm: begin
          mag_q  <= norm_mag;
          exp_q  <= norm_exp;
          zero_q <= norm_zero;
        end
        StRound: begin
          res_q       <= rnd_res;
          res_flags_q <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= out_load;
      if (out_load) begin
        sum_q   <= res_q;
        flags_q <= res_flags_q;
      end
    end
  end

  assign sum   = sum_q;
  assign flags = flags_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fpaddsub.sv
// Directed bench for fpaddsub: single-precision and half-precision instances.
module tb_fpaddsub;

  logic        clk;
  logic        reset;
  logic        op;
  logic        start_sp, start_hp;
  logic [31:0] a_sp, b_sp, sum_sp;
  logic [15:0] a_hp, b_hp, sum_hp;
  logic        done_sp, busy_sp, done_hp, busy_hp;
  logic [3:0]  flags_sp, flags_hp;

  int checks = 0;
  int errors = 0;

  fpaddsub u_sp (
    .clk   (clk),
    .reset (reset),
    .start (start_sp),
    .op    (op),
    .a     (a_sp),
    .b     (b_sp),
    .sum   (sum_sp),
    .done  (done_sp),
    .busy  (busy_sp),
    .flags (flags_sp)
  );

  fpaddsub #(
    .EXP_W (5),
    .MAN_W (10)
  ) u_hp (
    .clk   (clk),
    .reset (reset),
    .start (start_hp),
    .op    (op),
    .a     (a_hp),
    .b     (b_hp),
    .sum   (sum_hp),
    .done  (done_hp),
    .busy  (busy_hp),
    .flags (flags_hp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one operation and check latency, result, flags and strobe width.
  task automatic run(input string tag, input bit hp, input logic [31:0] av,
                     input logic [31:0] bv, input logic opv, input logic [31:0] exp_sum,
                     input logic [3:0] exp_flags, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    op = opv;
    if (hp) begin
      a_hp     = av[15:0];
      b_hp     = bv[15:0];
      start_hp = 1'b1;
    end else begin
      a_sp     = av;
      b_sp     = bv;
      start_sp = 1'b1;
    end
    @(posedge clk);
    #1;
    start_sp = 1'b0;
    start_hp = 1'b0;
    check({tag, " busy"}, 64'(hp ? busy_hp : busy_sp), 64'd1);
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if ((hp ? done_hp : done_sp) === 1'b1) lat = i;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " sum"}, 64'(hp ? {16'd0, sum_hp} : sum_sp), 64'(exp_sum));
    check({tag, " flags"}, 64'(hp ? flags_hp : flags_sp), 64'(exp_flags));
    @(posedge clk);
    #1;
    check({tag, " done width"}, 64'(hp ? done_hp : done_sp), 64'd0);
    check({tag, " sum held"}, 64'(hp ? {16'd0, sum_hp} : sum_sp), 64'(exp_sum));
  endtask

  initial begin
    int lat;
    int dones;
    reset    = 1'b0;
    op       = 1'b0;
    start_sp = 1'b0;
    start_hp = 1'b0;
    a_sp     = '0;
    b_sp     = '0;
    a_hp     = '0;
    b_hp     = '0;
    #2;
    check("reset sum", 64'(sum_sp), 64'd0);
    check("reset flags", 64'(flags_sp), 64'd0);
    check("reset done", 64'(done_sp), 64'd0);
    check("reset busy", 64'(busy_sp), 64'd0);
    check("reset hp busy", 64'(busy_hp), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single precision.
    run("add 1+2",      1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 5);
    run("cancel",       1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5);
    run("tie even",     1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5);
    run("tie odd",      1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 5);
    run("round carry",  1'b0, 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001, 5);
    run("sub neg",      1'b0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 5);
    run("overflow",     1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5);
    run("underflow",    1'b0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0010, 5);
    run("far sticky",   1'b0, 32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001, 5);
    run("subnormal in", 1'b0, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 5);
    run("inf-inf",      1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1);
    run("snan",         1'b0, 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1);
    run("inf+fin",      1'b0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1);
    run("-0 + -0",      1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1);

    // Half precision.
    run("hp 1+2",       1'b1, 32'h3C00, 32'h4000, 1'b0, 32'h4200, 4'b0000, 5);
    run("hp overflow",  1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b0101, 5);

    // start held while busy, with different operands: must not be queued.
    @(negedge clk);
    a_sp     = 32'h3F800000;
    b_sp     = 32'h40000000;
    op       = 1'b0;
    start_sp = 1'b1;
    @(posedge clk);
    #1;
    a_sp = 32'h7F800000;
    b_sp = 32'h7F800000;
    op   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start_sp = 1'b0;
    lat = 0;
    for (int i = 3; i <= 14 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (done_sp === 1'b1) lat = i;
    end
    check("busy ignore latency", 64'(lat), 64'd5);
    check("busy ignore sum", 64'(sum_sp), 64'h40400000);
    check("busy ignore flags", 64'(flags_sp), 64'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done_sp === 1'b1) dones++;
    end
    check("busy ignore no second done", 64'(dones), 64'd0);

    // Reset during NORM aborts the operation.
    @(negedge clk);
    a_sp     = 32'h3F800000;
    b_sp     = 32'h40000000;
    op       = 1'b0;
    start_sp = 1'b1;
    @(posedge clk);
    #1;
    start_sp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid-op busy", 64'(busy_sp), 64'd1);
    reset = 1'b0;
    #1;
    check("mid-op reset sum", 64'(sum_sp), 64'd0);
    check("mid-op reset busy", 64'(busy_sp), 64'd0);
    check("mid-op reset done", 64'(done_sp), 64'd0);
    check("mid-op reset flags", 64'(flags_sp), 64'd0);
    dones = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done_sp === 1'b1) dones++;
    end
    check("mid-op no done", 64'(dones), 64'd0);
    check("mid-op sum stays 0", 64'(sum_sp), 64'd0);
    run("after reset",  1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
